// File: rtl/cx_merge_arbiter_pkg.sv
// Shared types and reset constants for the CX2 merge arbiter.
// State encoding, channel index type and the flag values driven while in reset.
package cx_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      UP_REL,
      DN_REQ,
      DN_REL,
      ERR
   } state_t;

   typedef logic ch_t;

   localparam logic EXB_RESET = 1'b1;
   localparam logic CPY_RESET = 1'b0;

endpackage

// File: rtl/cx_merge_arbiter_sync.sv
// Asynchronous-reset flop chain used to bring a self-timed handshake line into the CLK domain.
module cx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cx_merge_arbiter.sv
// Two-channel round-robin merge of 4-phase bundled-data producers onto the CX2 Send/Ack input.
// All outputs are registered because they feed C-elements in the self-timed pipeline.
module cx_merge_arbiter
   import cx_arb_pkg::*;
#(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic              CLK,
   input  logic              MR_n,
   input  logic              Send_in0,
   input  logic [DATA_W-1:0] Data_in0,
   input  logic              CPY_in0,
   input  logic              EXB_in0,
   output logic              Ack_out0,
   input  logic              Send_in1,
   input  logic [DATA_W-1:0] Data_in1,
   input  logic              CPY_in1,
   input  logic              EXB_in1,
   output logic              Ack_out1,
   output logic              Send_out,
   output logic [DATA_W-1:0] Data_out,
   output logic              CPY,
   output logic              EXB,
   input  logic              Ack_in,
   output ch_t               Grant,
   output logic              Err_timeout
);

   localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC);

   logic             s0;
   logic             s1;
   logic             ack_s;
   state_t           state;
   ch_t              rr_ptr;
   ch_t              win;
   logic             cur_req;
   logic             timer_hit;
   logic [TMR_W-1:0] timer;

   cx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s0 (
      .clk   (CLK),
      .rst_n (MR_n),
      .d     (Send_in0),
      .q     (s0)
   );

   cx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_s1 (
      .clk   (CLK),
      .rst_n (MR_n),
      .d     (Send_in1),
      .q     (s1)
   );

   cx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
      .clk   (CLK),
      .rst_n (MR_n),
      .d     (Ack_in),
      .q     (ack_s)
   );

   // A lone request wins outright; a tie goes to rr_ptr.
   always_comb begin
      win = rr_ptr;
      if (s0 && !s1)      win = 1'b0;
      else if (s1 && !s0) win = 1'b1;
      cur_req   = (Grant == 1'b1) ? s1 : s0;
      timer_hit = (timer == TMR_LAST);
   end

   always_ff @(posedge CLK or negedge MR_n) begin
      if (!MR_n) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         timer       <= '0;
         Send_out    <= 1'b0;
         Ack_out0    <= 1'b0;
         Ack_out1    <= 1'b0;
         Data_out    <= '0;
         CPY         <= CPY_RESET;
         EXB         <= EXB_RESET;
         Grant       <= '0;
         Err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s0 || s1) begin
                  Data_out <= win ? Data_in1 : Data_in0;
                  CPY      <= win ? CPY_in1  : CPY_in0;
                  EXB      <= win ? EXB_in1  : EXB_in0;
                  Grant    <= win;
                  rr_ptr   <= ~win;
                  if (win) Ack_out1 <= 1'b1;
                  else     Ack_out0 <= 1'b1;
                  state    <= UP_REL;
               end
            end
            UP_REL: begin
               if (!cur_req) begin
                  Ack_out0 <= 1'b0;
                  Ack_out1 <= 1'b0;
                  Send_out <= 1'b1;
                  timer    <= '0;
                  state    <= DN_REQ;
               end
            end
            DN_REQ: begin
               if (ack_s) begin
                  Send_out <= 1'b0;
                  timer    <= '0;
                  state    <= DN_REL;
               end else if (timer_hit) begin
                  Send_out    <= 1'b0;
                  Err_timeout <= 1'b1;
                  timer       <= TMR_MAX;
                  state       <= ERR;
               end else if (timer != TMR_MAX) begin
                  timer <= timer + TMR_W'(1);
               end
            end
            DN_REL: begin
               if (!ack_s) begin
                  state <= IDLE;
               end else if (timer_hit) begin
                  Err_timeout <= 1'b1;
                  timer       <= TMR_MAX;
                  state       <= ERR;
               end else if (timer != TMR_MAX) begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ERR: begin
               Send_out    <= 1'b0;
               Ack_out0    <= 1'b0;
               Ack_out1    <= 1'b0;
               Err_timeout <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cx_merge_arbiter.sv
// Directed bench for cx_merge_arbiter: latency table, reset, timeout, fairness and a
// randomised downstream handshake against a per-channel scoreboard.
module tb_cx_merge_arbiter;

   localparam int DW  = 16;
   localparam int LIM = 400;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          cpy;
      logic          exb;
   } pkt_t;

   typedef struct {
      logic          ch;
      logic [DW-1:0] data;
      logic          cpy;
      logic          exb;
      logic [DW-1:0] exp_data;
      logic          exp_cpy;
      logic          exp_exb;
      logic          exp_grant;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          mr_n_a, mr_n_b, use_b;
   logic          send0, send1, cpy0, cpy1, exb0, exb1;
   logic [DW-1:0] data0, data1;
   logic          ack_in_a, ack_in_b;
   logic          ack0_a, ack1_a, so_a, cpy_a, exb_a, grant_a, err_a;
   logic          ack0_b, ack1_b, so_b, cpy_b, exb_b, grant_b, err_b;
   logic [DW-1:0] dout_a, dout_b;
   logic          ack0_m, ack1_m, so_m, cpy_m, exb_m, grant_m, err_m, ack_in_m;
   logic [DW-1:0] dout_m;

   int   n_pass = 0;
   int   n_total = 0;
   bit   aborted = 1'b0;
   bit   mon_en = 1'b0;
   int   mon_seen = 0;
   pkt_t q0[$];
   pkt_t q1[$];
   int   grant_log[$];
   logic so_prev = 1'b0;
   logic [1:0] ack_sync_m = 2'b00;
   logic ack_s_edge = 1'b0;

   cx_merge_arbiter #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT_CYC(15)) u_dut (
      .CLK(clk), .MR_n(mr_n_a),
      .Send_in0(send0), .Data_in0(data0), .CPY_in0(cpy0), .EXB_in0(exb0), .Ack_out0(ack0_a),
      .Send_in1(send1), .Data_in1(data1), .CPY_in1(cpy1), .EXB_in1(exb1), .Ack_out1(ack1_a),
      .Send_out(so_a), .Data_out(dout_a), .CPY(cpy_a), .EXB(exb_a), .Ack_in(ack_in_a),
      .Grant(grant_a), .Err_timeout(err_a)
   );

   cx_merge_arbiter #(.DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT_CYC(63)) u_dut_slow (
      .CLK(clk), .MR_n(mr_n_b),
      .Send_in0(send0), .Data_in0(data0), .CPY_in0(cpy0), .EXB_in0(exb0), .Ack_out0(ack0_b),
      .Send_in1(send1), .Data_in1(data1), .CPY_in1(cpy1), .EXB_in1(exb1), .Ack_out1(ack1_b),
      .Send_out(so_b), .Data_out(dout_b), .CPY(cpy_b), .EXB(exb_b), .Ack_in(ack_in_b),
      .Grant(grant_b), .Err_timeout(err_b)
   );

   always_comb begin
      ack0_m   = use_b ? ack0_b   : ack0_a;
      ack1_m   = use_b ? ack1_b   : ack1_a;
      so_m     = use_b ? so_b     : so_a;
      cpy_m    = use_b ? cpy_b    : cpy_a;
      exb_m    = use_b ? exb_b    : exb_a;
      grant_m  = use_b ? grant_b  : grant_a;
      err_m    = use_b ? err_b    : err_a;
      dout_m   = use_b ? dout_b   : dout_a;
      ack_in_m = use_b ? ack_in_b : ack_in_a;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic cur(input int id);
      case (id)
         0:       return ack0_m;
         1:       return ack1_m;
         default: return so_m;
      endcase
   endfunction

   task automatic wait_for(input int id, input logic val, input string name);
      int t = 0;
      while (!aborted && cur(id) !== val && t < LIM) begin
         @(negedge clk);
         t++;
      end
      if (!aborted && t >= LIM) begin
         n_total++;
         $display("FAIL %s: got no response, required within %0d cycles", name, LIM);
         aborted = 1'b1;
      end
   endtask

   task automatic set_ack(input logic v);
      if (use_b) ack_in_b = v;
      else       ack_in_a = v;
   endtask

   task automatic drive(input logic ch, input logic s, input pkt_t p);
      if (ch) begin send1 = s; data1 = p.data; cpy1 = p.cpy; exb1 = p.exb; end
      else    begin send0 = s; data0 = p.data; cpy0 = p.cpy; exb0 = p.exb; end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_send_out"}, 32'(so_m), 0);
      check({tag, "_acks"}, 32'({ack1_m, ack0_m}), 0);
      check({tag, "_data_out"}, 32'(dout_m), 0);
      check({tag, "_cpy"}, 32'(cpy_m), 0);
      check({tag, "_exb"}, 32'(exb_m), 1);
      check({tag, "_grant"}, 32'(grant_m), 0);
      check({tag, "_err"}, 32'(err_m), 0);
   endtask

   // Caller sits on a negedge with the DUT idle; returns on the negedge after Send_out rises.
   task automatic start_packet(input logic ch, input pkt_t p);
      logic [1:0] ack_exp;
      ack_exp = ch ? 2'b10 : 2'b01;
      drive(ch, 1'b1, p);
      repeat (2) @(negedge clk);
      check("ack_not_before_sync", 32'({ack1_m, ack0_m}), 0);
      @(negedge clk);
      check("ack_latency", 32'({ack1_m, ack0_m}), 32'(ack_exp));
      drive(ch, 1'b0, p);
      repeat (2) @(negedge clk);
      check("send_out_not_early", 32'(so_m), 0);
      @(negedge clk);
      check("send_out_latency", 32'(so_m), 1);
      check("ack_released", 32'({ack1_m, ack0_m}), 0);
   endtask

   task automatic finish_dn();
      set_ack(1'b1);
      repeat (2) @(negedge clk);
      check("send_out_held_until_ack_s", 32'(so_m), 1);
      @(negedge clk);
      check("send_out_fall_latency", 32'(so_m), 0);
      set_ack(1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic reset_a();
      @(negedge clk);
      mr_n_a = 1'b0;
      repeat (2) @(negedge clk);
      mr_n_a = 1'b1;
      @(negedge clk);
   endtask

   task automatic producer(input logic ch, input int n, input int gmin, input int gmax);
      pkt_t p;
      for (int i = 0; i < n; i++) begin
         if (aborted) return;
         p.data = DW'($urandom);
         p.cpy  = 1'($urandom_range(1, 0));
         p.exb  = 1'($urandom_range(1, 0));
         if (ch) q1.push_back(p);
         else    q0.push_back(p);
         drive(ch, 1'b1, p);
         wait_for(int'(ch), 1'b1, "producer_ack_rise");
         drive(ch, 1'b0, p);
         wait_for(int'(ch), 1'b0, "producer_ack_fall");
         repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      end
   endtask

   task automatic downstream(input int n, input int max_dly);
      for (int i = 0; i < n; i++) begin
         if (aborted) return;
         wait_for(2, 1'b1, "downstream_send_out_rise");
         repeat ($urandom_range(max_dly, 0)) @(negedge clk);
         set_ack(1'b1);
         wait_for(2, 1'b0, "downstream_send_out_fall");
         repeat ($urandom_range(max_dly, 0)) @(negedge clk);
         set_ack(1'b0);
      end
   endtask

   task automatic on_rise();
      pkt_t e;
      check("dn_ack_s_low_at_rise", 32'(ack_s_edge), 0);
      grant_log.push_back(int'(grant_m));
      mon_seen++;
      if (grant_m) begin
         check("sb_ch1_pending", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("sb_ch1_packet", 32'({dout_m, cpy_m, exb_m}), 32'(e));
         end
      end else begin
         check("sb_ch0_pending", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("sb_ch0_packet", 32'({dout_m, cpy_m, exb_m}), 32'(e));
         end
      end
   endtask

   // Reference copy of the Ack_in synchronizer: the value the FSM acted on at each edge.
   always @(posedge clk) begin
      ack_sync_m <= {ack_sync_m[0], ack_in_m};
      ack_s_edge <= ack_sync_m[1];
   end

   always @(negedge clk) begin
      if (mon_en && so_m === 1'b1 && so_prev === 1'b0) on_rise();
      so_prev <= so_m;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      pkt_t p;
      int   base;
      tbl[0] = '{ch:1'b0, data:16'hA5A5, cpy:1'b1, exb:1'b0, exp_data:16'hA5A5, exp_cpy:1'b1, exp_exb:1'b0, exp_grant:1'b0};
      tbl[1] = '{ch:1'b1, data:16'h5A5A, cpy:1'b0, exb:1'b1, exp_data:16'h5A5A, exp_cpy:1'b0, exp_exb:1'b1, exp_grant:1'b1};
      tbl[2] = '{ch:1'b0, data:16'hFFFF, cpy:1'b1, exb:1'b1, exp_data:16'hFFFF, exp_cpy:1'b1, exp_exb:1'b1, exp_grant:1'b0};
      tbl[3] = '{ch:1'b1, data:16'h0000, cpy:1'b0, exb:1'b0, exp_data:16'h0000, exp_cpy:1'b0, exp_exb:1'b0, exp_grant:1'b1};
      tbl[4] = '{ch:1'b1, data:16'h1234, cpy:1'b1, exb:1'b0, exp_data:16'h1234, exp_cpy:1'b1, exp_exb:1'b0, exp_grant:1'b1};

      mr_n_a = 1'b0; mr_n_b = 1'b0; use_b = 1'b0;
      send0 = 1'b0; send1 = 1'b0; cpy0 = 1'b0; cpy1 = 1'b0; exb0 = 1'b0; exb1 = 1'b0;
      data0 = '0; data1 = '0; ack_in_a = 1'b0; ack_in_b = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      mr_n_a = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         p.data = tbl[i].data; p.cpy = tbl[i].cpy; p.exb = tbl[i].exb;
         start_packet(tbl[i].ch, p);
         check("tbl_data_out", 32'(dout_m), 32'(tbl[i].exp_data));
         check("tbl_cpy", 32'(cpy_m), 32'(tbl[i].exp_cpy));
         check("tbl_exb", 32'(exb_m), 32'(tbl[i].exp_exb));
         check("tbl_grant", 32'(grant_m), 32'(tbl[i].exp_grant));
         finish_dn();
      end

      p = '{data:16'h3C3C, cpy:1'b1, exb:1'b0};
      start_packet(1'b0, p);
      #2 mr_n_a = 1'b0;
      #1 check_reset_outputs("mid_dn_req");
      @(negedge clk);
      mr_n_a = 1'b1;
      @(negedge clk);

      p = '{data:16'h0F0F, cpy:1'b0, exb:1'b1};
      start_packet(1'b0, p);
      repeat (14) @(negedge clk);
      check("err_not_before_timeout", 32'(err_m), 0);
      check("send_out_before_timeout", 32'(so_m), 1);
      @(negedge clk);
      check("err_at_timeout", 32'(err_m), 1);
      check("send_out_after_timeout", 32'(so_m), 0);
      drive(1'b0, 1'b1, p);
      repeat (8) @(negedge clk);
      check("err_no_new_ack", 32'({ack1_m, ack0_m}), 0);
      check("err_sticky", 32'(err_m), 1);
      check("err_data_held", 32'(dout_m), 32'h0F0F);
      drive(1'b0, 1'b0, p);
      reset_a();

      mon_en = 1'b1;
      grant_log.delete();
      for (int r = 0; r < 2; r++) begin
         fork
            producer(1'b0, 1, 0, 0);
            producer(1'b1, 1, 0, 0);
            downstream(2, 0);
         join
         repeat (4) @(negedge clk);
      end
      check("tie_grant_count", 32'(grant_log.size()), 4);
      for (int i = 0; i < grant_log.size() && i < 4; i++)
         check("tie_grant_order", 32'(grant_log[i]), 32'(i % 2));

      reset_a();
      grant_log.delete();
      fork
         producer(1'b0, 4, 2, 2);
         producer(1'b1, 4, 0, 0);
         downstream(8, 0);
      join
      repeat (4) @(negedge clk);
      check("alt_grant_count", 32'(grant_log.size()), 8);
      for (int i = 0; i < grant_log.size() && i < 8; i++)
         check("alt_grant_order", 32'(grant_log[i]), 32'(i % 2));

      mr_n_a = 1'b0;
      use_b = 1'b1;
      @(negedge clk);
      mr_n_b = 1'b1;
      repeat (2) @(negedge clk);
      base = mon_seen;
      fork
         producer(1'b0, 50, 0, 3);
         producer(1'b1, 50, 0, 3);
         downstream(100, 20);
      join
      repeat (5) @(negedge clk);
      check("rand_packet_count", 32'(mon_seen - base), 100);
      check("rand_sb_ch0_drained", 32'(q0.size()), 0);
      check("rand_sb_ch1_drained", 32'(q1.size()), 0);
      check("rand_no_timeout", 32'(err_m), 0);
      check("rand_send_out_idle", 32'(so_m), 0);
      mon_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
